// File: rtl/dma_xfer_engine.sv
// Single-mode byte sequencer behind the I8237 register/priority block: one byte
// per arbitration, moved between a DREQ/DACK device and the memory bus.
module dma_xfer_engine #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iEn,
  input  logic [3:0]  iReq,
  input  logic [3:0]  iDirWr,
  input  logic [23:0] iAdr0,
  input  logic [23:0] iAdr1,
  input  logic [23:0] iAdr2,
  input  logic [23:0] iAdr3,
  input  logic [15:0] iCnt0,
  input  logic [15:0] iCnt1,
  input  logic [15:0] iCnt2,
  input  logic [15:0] iCnt3,
  output logic [3:0]  oDack,
  input  logic [7:0]  iDevData,
  output logic [7:0]  oDevData,
  output logic        oDevStb,
  output logic [23:0] oMemAdr,
  output logic [1:0]  oMemRW,
  output logic [7:0]  oMemData,
  input  logic [7:0]  iMemData,
  input  logic        iMemAck,
  output logic [3:0]  oStep,
  output logic [3:0]  oTC,
  output logic        oErr,
  output logic        oBusy,
  output logic [1:0]  oDbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    MEM  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic        dir_q, dir_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] adr_q, adr_d;
  logic [7:0]  buf_q, buf_d;
  logic [15:0] wait_q, wait_d;
  logic [3:0]  dack_q, dack_d;
  logic [1:0]  rw_q, rw_d;
  logic [7:0]  devdata_q, devdata_d;
  logic        devstb_q, devstb_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  tc_q, tc_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [1:0]  grant_ch;
  logic [23:0] grant_adr;
  logic [15:0] grant_cnt;
  logic [3:0]  ch_onehot;

  // Fixed priority: channel 0 wins.
  always_comb begin
    casez (iReq)
      4'b???1: grant_ch = 2'd0;
      4'b??10: grant_ch = 2'd1;
      4'b?100: grant_ch = 2'd2;
      default: grant_ch = 2'd3;
    endcase
  end

  always_comb begin
    case (grant_ch)
      2'd0:    begin grant_adr = iAdr0; grant_cnt = iCnt0; end
      2'd1:    begin grant_adr = iAdr1; grant_cnt = iCnt1; end
      2'd2:    begin grant_adr = iAdr2; grant_cnt = iCnt2; end
      default: begin grant_adr = iAdr3; grant_cnt = iCnt3; end
    endcase
  end

  assign ch_onehot = 4'b0001 << ch_q;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    buf_d     = buf_q;
    wait_d    = wait_q;
    dack_d    = dack_q;
    rw_d      = rw_q;
    devdata_d = devdata_q;
    devstb_d  = 1'b0;
    step_d    = 4'b0000;
    tc_d      = 4'b0000;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (iEn && (iReq != 4'b0000)) begin
          ch_d    = grant_ch;
          adr_d   = grant_adr;
          cnt_d   = grant_cnt;
          dir_d   = iDirWr[grant_ch];
          dack_d  = 4'b0001 << grant_ch;
          state_d = ACK;
        end
      end
      ACK: begin
        if (dir_q) buf_d = iDevData;
        rw_d    = dir_q ? 2'b01 : 2'b10;
        wait_d  = 16'd0;
        state_d = MEM;
      end
      MEM: begin
        // Ack is checked first so it beats a timeout landing in the same cycle.
        if (iMemAck) begin
          if (!dir_q) devdata_d = iMemData;
          rw_d     = 2'b00;
          step_d   = ch_onehot;
          tc_d     = (cnt_q == 16'h0000) ? ch_onehot : 4'b0000;
          devstb_d = !dir_q;
          state_d  = DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          rw_d    = 2'b00;
          dack_d  = 4'b0000;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      DONE: begin
        dack_d  = 4'b0000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      ch_q      <= 2'd0;
      dir_q     <= 1'b0;
      cnt_q     <= 16'd0;
      adr_q     <= 24'd0;
      buf_q     <= 8'd0;
      wait_q    <= 16'd0;
      dack_q    <= 4'b0000;
      rw_q      <= 2'b00;
      devdata_q <= 8'd0;
      devstb_q  <= 1'b0;
      step_q    <= 4'b0000;
      tc_q      <= 4'b0000;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      buf_q     <= buf_d;
      wait_q    <= wait_d;
      dack_q    <= dack_d;
      rw_q      <= rw_d;
      devdata_q <= devdata_d;
      devstb_q  <= devstb_d;
      step_q    <= step_d;
      tc_q      <= tc_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign oDack     = dack_q;
  assign oDevData  = devdata_q;
  assign oDevStb   = devstb_q;
  assign oMemAdr   = adr_q;
  assign oMemRW    = rw_q;
  assign oMemData  = buf_q;
  assign oStep     = step_q;
  assign oTC       = tc_q;
  assign oErr      = err_q;
  assign oBusy     = busy_q;
  assign oDbgState = state_q;

endmodule
